// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: board-level reset synchroniser and sequencer.
// The combined board/PCIe reset deasserts synchronously into clk. All outputs
// are held low for MIN_HOLD cycles. The NUM_OUT downstream domains (npor,
// fabric, DDR, user) are then released in order. Each release waits for a
// minimum gap and, optionally, for that stage's ready/lock input. A timeout
// on that wait is reported as an error.
module rst_seq_ctrl #(
  parameter int                 NUM_OUT     = 4,
  parameter int                 SYNC_STAGES = 2,
  parameter int                 MIN_HOLD    = 16,
  parameter int                 STAGE_GAP   = 8,
  parameter int                 TIMEOUT     = 1024,
  parameter logic [NUM_OUT-1:0] READY_MASK  = {NUM_OUT{1'b1}}
) (
  input  logic               clk,
  input  logic               any_rstn,
  input  logic               soft_rst_req,
  input  logic [NUM_OUT-1:0] stage_ready,
  output logic [NUM_OUT-1:0] rst_n_out,
  output logic               seq_done,
  output logic               timeout_err,
  output logic [2:0]         err_stage,
  output logic [2:0]         state_o
);

  // The counter covers both the hold phase and the longest ready wait.
  localparam int CNT_W = $clog2(TIMEOUT + MIN_HOLD + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MIN_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [2:0]       LAST_IDX  = 3'(NUM_OUT - 1);

  // The mask is padded to the full 3-bit stage index range, so indexing
  // by idx is always in range whatever NUM_OUT is.
  localparam logic [7:0]       MASK_EXT  = 8'(READY_MASK);

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_HOLD  = 3'd1,
    S_WAIT  = 3'd2,
    S_RUN   = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [2:0]             idx;

  logic [SYNC_STAGES-1:0] rst_sync_p;
  logic                   rstn_s;

  logic [NUM_OUT-1:0]     rdy_sync_p [SYNC_STAGES];
  logic [NUM_OUT-1:0]     rdy_s;
  logic [7:0]             rdy_ext;

  logic                   gap_ok;
  logic                   rdy_ok;
  logic                   cond;
  logic                   soft_hit;

  // ---- stage boundary: reset deassertion synchroniser ----
  // Assertion is asynchronous; a '1' shifts in so that release is clk-aligned.
  always_ff @(posedge clk or negedge any_rstn) begin
    if (!any_rstn) begin
      rst_sync_p <= '0;
    end else begin
      rst_sync_p <= {rst_sync_p[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rstn_s = rst_sync_p[SYNC_STAGES-1];

  // ---- stage boundary: per-stage ready synchronisers ----
  // Each stage_ready bit is asynchronous (PLL lock, cal done) and gets its
  // own chain. The chain is cleared together with the reset.
  always_ff @(posedge clk or negedge any_rstn) begin
    if (!any_rstn) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        rdy_sync_p[i] <= '0;
      end
    end else begin
      rdy_sync_p[0] <= stage_ready;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        rdy_sync_p[i] <= rdy_sync_p[i-1];
      end
    end
  end

  assign rdy_s   = rdy_sync_p[SYNC_STAGES-1];
  assign rdy_ext = 8'(rdy_s);

  // Release condition for the current stage. The gap must have elapsed.
  // The stage must also report ready, unless it is masked out of the wait.
  assign gap_ok   = (cnt >= GAP_LAST);
  assign rdy_ok   = rdy_ext[idx] || !MASK_EXT[idx];
  assign cond     = gap_ok && rdy_ok;

  // A soft request has no effect before the first synchronised release.
  assign soft_hit = soft_rst_req && (state != S_RESET);

  // ---- stage boundary: sequencing FSM with registered outputs ----
  // Outputs are set only here, so nothing combinational reaches the pins.
  // Within one sequence, released bits are only ever set, never cleared.
  always_ff @(posedge clk or negedge any_rstn) begin
    if (!any_rstn) begin
      state       <= S_RESET;
      cnt         <= '0;
      idx         <= '0;
      rst_n_out   <= '0;
      seq_done    <= 1'b0;
      timeout_err <= 1'b0;
      err_stage   <= '0;
    end else if (soft_hit) begin
      // Re-run the sequence from HOLD. The input synchroniser stays settled.
      state       <= S_HOLD;
      cnt         <= '0;
      idx         <= '0;
      rst_n_out   <= '0;
      seq_done    <= 1'b0;
      timeout_err <= 1'b0;
      err_stage   <= '0;
    end else begin
      case (state)
        S_RESET: begin
          if (rstn_s) begin
            state <= S_HOLD;
            cnt   <= '0;
          end
        end

        S_HOLD: begin
          if (cnt == HOLD_LAST) begin
            rst_n_out[0] <= 1'b1;
            idx          <= '0;
            cnt          <= '0;
            state        <= S_WAIT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_WAIT: begin
          // A ready stage wins over a timeout that falls on the same cycle.
          if (cond) begin
            if (idx == LAST_IDX) begin
              seq_done <= 1'b1;
              state    <= S_RUN;
            end else begin
              for (int k = 0; k < NUM_OUT; k++) begin
                if (3'(k) == idx + 3'd1) begin
                  rst_n_out[k] <= 1'b1;
                end
              end
              idx <= idx + 3'd1;
              cnt <= '0;
            end
          end else if (cnt == TO_LAST) begin
            timeout_err <= 1'b1;
            err_stage   <= idx;
            state       <= S_ERR;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_RUN: begin
          // Fully released; later ready changes are deliberately ignored.
        end

        S_ERR: begin
          // Stages already released stay up. Leaving ERR takes a soft
          // request or a board reset.
        end

        default: begin
          state <= S_RESET;
        end
      endcase
    end
  end

  assign state_o = state;

endmodule
